// File: rtl/l1_refill_pkg.sv
// Shared types and block geometry for the L1 miss/refill sequencer.
package l1_refill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BEAT,
        DELIVER,
        ERR
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_OFS_W      = 2;

endpackage

// File: rtl/l1_refill_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the I-side, bit 1 the D-side.
module rr_arb2
    import l1_refill_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt
);

    // NOTE: gnt gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last == OWN_I) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/l1_refill_ctrl.sv
// Miss/refill sequencer: arbitrates I/D L1 misses, fetches a 4-beat block, returns the line.
module l1_refill_ctrl
    import l1_refill_pkg::*;
#(
    parameter int ADDR_W      = 30,
    parameter int WORD_W      = BLOCK_W / WORDS_PER_BLOCK,
    parameter int BEATS       = WORDS_PER_BLOCK,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_miss,
    input  logic [ADDR_W-1:0]       i_addr,
    output logic                    i_delivered,
    output logic [BEATS*WORD_W-1:0] i_blockin,
    input  logic                    d_miss,
    input  logic [ADDR_W-1:0]       d_addr,
    output logic                    d_delivered,
    output logic [BEATS*WORD_W-1:0] d_blockin,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [WORD_W-1:0]       mem_rdata,
    output logic                    busy,
    output logic                    err
);

    localparam int LINE_W = BEATS * WORD_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int TO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEATS - 1);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_q,  last_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [LINE_W-1:0]   line_q,  line_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [TO_W-1:0]     to_q,    to_d;

    logic [1:0]          arb_gnt;
    logic [ADDR_W-1:0]   pick_addr;

    rr_arb2 u_arb (
        .req  ({d_miss, i_miss}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    assign pick_addr = arb_gnt[1] ? d_addr : i_addr;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        line_d  = line_q;
        beat_d  = beat_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    owner_d = arb_gnt[1] ? OWN_D : OWN_I;
                    addr_d  = pick_addr & ALIGN_MASK;
                    beat_d  = '0;
                    to_d    = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    to_d    = '0;
                    beat_d  = '0;
                    state_d = BEAT;
                end else if (to_q == TO_W'(MEM_TIMEOUT - 1)) begin
                    to_d    = '0;
                    state_d = ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            BEAT: begin
                if (mem_rvalid) begin
                    line_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
                    beat_d = beat_q + 1'b1;
                    to_d   = '0;
                    if (beat_q == BEAT_W'(BEATS - 1)) state_d = DELIVER;
                end else if (to_q == TO_W'(MEM_TIMEOUT - 1)) begin
                    to_d    = '0;
                    state_d = ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            DELIVER: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    // NOTE: the line buffer is reset too, since it drives the blockin outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_D;
            addr_q  <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            to_q    <= to_d;
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign busy        = (state_q != IDLE);
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign err         = (state_q == ERR);
    assign i_delivered = (state_q == DELIVER) && (owner_q == OWN_I);
    assign d_delivered = (state_q == DELIVER) && (owner_q == OWN_D);
    assign i_blockin   = line_q;
    assign d_blockin   = line_q;

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Randomized self-checking bench for l1_refill_ctrl against a transaction-level model.
module tb_l1_refill_ctrl;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_miss = 1'b0, d_miss = 1'b0;
    logic [29:0]  i_addr = '0, d_addr = '0;
    logic         i_delivered, d_delivered;
    logic [127:0] i_blockin, d_blockin;
    logic         mem_req;
    logic [29:0]  mem_addr;
    logic         mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         busy, err;

    int           n_total = 0;
    int           n_bad = 0;
    bit           last_d = 1'b1;
    logic [31:0]  beat_data [4];

    l1_refill_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_miss      (i_miss),
        .i_addr      (i_addr),
        .i_delivered (i_delivered),
        .i_blockin   (i_blockin),
        .d_miss      (d_miss),
        .d_addr      (d_addr),
        .d_delivered (d_delivered),
        .d_blockin   (d_blockin),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] align(input logic [29:0] a);
        return (a >> l1_refill_pkg::WORD_OFS_W) << l1_refill_pkg::WORD_OFS_W;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_req"},  128'(mem_req), 128'(0));
        check({tag, "_addr"}, 128'(mem_addr), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_err"},  128'(err), 128'(0));
        check({tag, "_dlv"},  128'({i_delivered, d_delivered}), 128'(0));
        check({tag, "_ibl"},  i_blockin, 128'(0));
        check({tag, "_dbl"},  d_blockin, 128'(0));
    endtask

    // Waits (bounded) at falling edges for mem_req; cyc is the number of extra edges waited.
    task automatic wait_req(output int cyc);
        cyc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_req) begin
                cyc = i;
                break;
            end
        end
        check("req_seen", 128'(cyc >= 0), 128'(1));
    endtask

    // One full fetch: expected owner follows the round-robin rule over pending misses.
    task automatic run_fetch(input int gnt_wait, input int gap, input bit rv_in_req,
                             input bit rand_beats, output int req_lat);
        bit           own_d;
        logic [127:0] line;
        own_d = (i_miss && d_miss) ? !last_d : d_miss;
        if (rand_beats) begin
            for (int k = 0; k < 4; k++) beat_data[k] = $urandom;
        end
        line = {beat_data[3], beat_data[2], beat_data[1], beat_data[0]};
        wait_req(req_lat);
        check("mem_addr", 128'(mem_addr), 128'(align(own_d ? d_addr : i_addr)));
        for (int w = 0; w < gnt_wait; w++) begin
            if (rv_in_req && w == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hdead_beef;
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            check("req_held", 128'(mem_req), 128'(1));
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("req_drop", 128'(mem_req), 128'(0));
        check("busy_beat", 128'(busy), 128'(1));
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = beat_data[k];
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    check("early_dlv", 128'({i_delivered, d_delivered}), 128'(0));
                    @(negedge clk);
                end
            end
        end
        check("i_dlv", 128'(i_delivered), 128'(!own_d));
        check("d_dlv", 128'(d_delivered), 128'(own_d));
        check("line", own_d ? d_blockin : i_blockin, line);
        check("dlv_err", 128'(err), 128'(0));
        if (own_d) d_miss = 1'b0;
        else       i_miss = 1'b0;
        last_d = own_d;
        @(negedge clk);
        check("dlv_once", 128'({i_delivered, d_delivered}), 128'(0));
        check("idle", 128'(busy), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        int lat, n, found;

        // Reset state and quiet idle.
        #3;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_req", 128'(mem_req), 128'(0));

        // Basic I-side fetch with fixed beats.
        i_miss = 1'b1;
        i_addr = 30'h0000_1235;
        beat_data[0] = 32'h1111_1111;
        beat_data[1] = 32'h2222_2222;
        beat_data[2] = 32'h3333_3333;
        beat_data[3] = 32'h4444_4444;
        run_fetch(0, 0, 1'b0, 1'b0, lat);
        check("req_latency", 128'(lat), 128'(0));
        check("fixed_line", i_blockin, 128'h44444444_33333333_22222222_11111111);

        // Fresh reset, then simultaneous misses alternate starting with I.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        last_d = 1'b1;
        i_miss = 1'b1; i_addr = 30'($urandom);
        d_miss = 1'b1; d_addr = 30'($urandom);
        run_fetch(1, 0, 1'b0, 1'b1, lat);
        check("first_is_i", 128'(d_miss), 128'(1));
        run_fetch(0, 1, 1'b0, 1'b1, lat);
        i_miss = 1'b1; i_addr = 30'($urandom);
        d_miss = 1'b1; d_addr = 30'($urandom);
        run_fetch(2, 0, 1'b0, 1'b1, lat);
        check("alt_is_i", 128'(d_miss), 128'(1));
        run_fetch(0, 0, 1'b0, 1'b1, lat);
        d_miss = 1'b1; d_addr = 30'($urandom);
        run_fetch(0, 2, 1'b0, 1'b1, lat);
        d_miss = 1'b1; d_addr = 30'($urandom);
        run_fetch(1, 0, 1'b0, 1'b1, lat);

        // Stray rvalid during REQ and 3-cycle beat gaps.
        i_miss = 1'b1; i_addr = 30'($urandom);
        run_fetch(2, 3, 1'b1, 1'b1, lat);

        // Timeout with no grant, then retry of the same miss.
        i_miss = 1'b1; i_addr = 30'h2AB_CDE7;
        wait_req(lat);
        check("to_addr", 128'(mem_addr), 128'(align(30'h2AB_CDE7)));
        n = 0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (err) begin
                found = 1;
                break;
            end
            check("to_req", 128'(mem_req), 128'(1));
            n++;
            @(negedge clk);
        end
        check("err_seen", 128'(found), 128'(1));
        check("to_cycles", 128'(n), 128'(TO));
        check("err_req", 128'(mem_req), 128'(0));
        check("err_dlv", 128'({i_delivered, d_delivered}), 128'(0));
        @(negedge clk);
        check("err_pulse", 128'(err), 128'(0));
        run_fetch(1, 1, 1'b0, 1'b1, lat);

        // Reset in the middle of a beat sequence, then a clean refetch.
        d_miss = 1'b1; d_addr = 30'($urandom);
        wait_req(lat);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom | 32'h1;
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        check_zero("rst_hold");
        rst_n  = 1'b1;
        last_d = 1'b1;
        run_fetch(0, 1, 1'b0, 1'b1, lat);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            if (!i_miss && $urandom_range(1) == 1) begin
                i_miss = 1'b1; i_addr = 30'($urandom);
            end
            if (!d_miss && $urandom_range(1) == 1) begin
                d_miss = 1'b1; d_addr = 30'($urandom);
            end
            if (!i_miss && !d_miss) begin
                i_miss = 1'b1; i_addr = 30'($urandom);
            end
            run_fetch($urandom_range(4), $urandom_range(3), 1'($urandom_range(1)), 1'b1, lat);
        end
        i_miss = 1'b0;
        d_miss = 1'b0;
        repeat (3) @(negedge clk);
        check("end_idle", 128'(busy), 128'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
